// File: rtl/modulo5_stream_scheduler.sv
// modulo5_stream_scheduler: round-robin front end feeding words MSB-first into a serial mod-5 detector
module modulo5_stream_scheduler #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    input  logic [WIDTH-1:0] req_data0,
    input  logic [WIDTH-1:0] req_data1,
    output logic [1:0]       req_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [2:0]       res_remainder,
    output logic             res_divisible,
    output logic             res_id,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;
    state_t           state;
    logic             ptr;
    logic [5:0]       cnt;
    logic [WIDTH-1:0] sreg;
    logic             grant;
    logic             det_rst;
    logic             det_en;
    logic [2:0]       det_rem;

    assign grant     = &req_valid ? ptr : req_valid[1];
    assign req_ready = (state == IDLE && !reset && |req_valid) ? (grant ? 2'b10 : 2'b01) : 2'b00;
    assign det_rst   = reset || state == CLEAR;
    assign det_en    = det_rst || state == SHIFT;
    assign res_valid = state == DONE;
    assign res_remainder = res_valid ? det_rem : 3'd0;
    assign res_divisible = res_valid && det_rem == 3'd0;
    assign busy      = state != IDLE;

    ModuloDetector u_det (
        .clock     (clock),
        .reset     (det_rst),
        .en        (det_en),
        .din       (sreg[WIDTH-1]),
        .remainder (det_rem)
    );

    // Accept a word, clear the detector, stream WIDTH bits, then hold the result until taken
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            ptr    <= 1'b0;
            cnt    <= '0;
            sreg   <= '0;
            res_id <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|req_valid) begin
                    sreg   <= grant ? req_data1 : req_data0;
                    res_id <= grant;
                    ptr    <= ~grant;
                    state  <= CLEAR;
                end
                CLEAR: begin
                    cnt   <= '0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    sreg <= sreg << 1;
                    cnt  <= cnt + 6'd1;
                    if (cnt == 6'(WIDTH - 1)) state <= DONE;
                end
                DONE: if (res_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// ModuloDetector: serial remainder of an MSB-first bit stream modulo 5
module ModuloDetector (
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    input  logic       din,
    output logic [2:0] remainder
);
    logic [3:0] doubled;

    assign doubled = {remainder, din};

    // Remainder becomes (2r + bit) mod 5; reset and updates only take effect while enabled
    always_ff @(posedge clock) begin
        if (en) remainder <= reset ? 3'd0 : (doubled >= 4'd5 ? 3'(doubled - 4'd5) : doubled[2:0]);
    end
endmodule
